// File: rtl/ibex_arb_pkg.sv
// Shared types and limits for the Ibex instruction/data memory arbiter.
package ibex_arb_pkg;

    // Identifies which Ibex port owns a memory transaction.
    typedef enum logic {
        SrcInstr,
        SrcData
    } arb_src_e;

    // Largest supported number of accepted-but-unanswered transactions.
    localparam int unsigned MaxOutstandingLimit = 4;

    // Counter width able to hold 0..MaxOutstandingLimit.
    localparam int unsigned CntW = $clog2(MaxOutstandingLimit + 1);

    // Round-robin helper: the side opposite to the given one.
    function automatic arb_src_e other_src(arb_src_e src);
        return (src == SrcInstr) ? SrcData : SrcInstr;
    endfunction

endpackage

// File: rtl/ibex_arb_src_fifo.sv
// In-order FIFO of source IDs for granted memory transactions; the head
// names the port that owns the next response.
module ibex_arb_src_fifo
    import ibex_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  arb_src_e src_i,
    input  logic     pop_i,
    output arb_src_e head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    arb_src_e            mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Overflow/underflow guards keep the count inside 0..DEPTH.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers wrap at DEPTH, which need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= SrcInstr;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= src_i;
            end
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Arbitrates the Ibex instruction-fetch and LSU ports onto one shared memory
// port and routes in-order responses back to the port that issued them.
module ibex_mem_arbiter
    import ibex_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2, // legal range 1..MaxOutstandingLimit
    parameter int unsigned DATA_FIRST      = 1  // tie winner after reset: 1 data, 0 instr
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        protocol_err_o
);

    localparam arb_src_e LastInit = (DATA_FIRST != 0) ? SrcInstr : SrcData;

    arb_src_e winner;
    arb_src_e last_q, last_d;
    arb_src_e hold_src_q, hold_src_d;
    logic     hold_valid_q, hold_valid_d;
    logic     protocol_err_q, protocol_err_d;
    logic     fifo_full, fifo_empty;
    arb_src_e fifo_head;
    logic     grant, pop;

    // Pick the winner: a pending (ungranted) choice sticks, otherwise
    // a lone requester wins, otherwise the side that lost last time.
    always_comb begin
        winner = other_src(last_q);
        if (hold_valid_q) begin
            winner = hold_src_q;
        end else if (instr_req_i && !data_req_i) begin
            winner = SrcInstr;
        end else if (data_req_i && !instr_req_i) begin
            winner = SrcData;
        end
    end

    // Request and grants; rst_ni gating keeps handshakes low while in reset.
    always_comb begin
        mem_req_o   = (instr_req_i | data_req_i) & ~fifo_full & rst_ni;
        grant       = mem_req_o & mem_gnt_i;
        instr_gnt_o = grant & (winner == SrcInstr);
        data_gnt_o  = grant & (winner == SrcData);
    end

    // Shared request fields follow the winner; fetches are full-word reads.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (winner == SrcData) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // Response routing: a response pops the FIFO and goes to its head source.
    always_comb begin
        pop            = mem_rvalid_i & ~fifo_empty;
        instr_rvalid_o = pop & (fifo_head == SrcInstr);
        data_rvalid_o  = pop & (fifo_head == SrcData);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        instr_err_o    = instr_rvalid_o & mem_err_i;
        data_err_o     = data_rvalid_o & mem_err_i;
    end

    // Next-state for arbitration history and the sticky protocol flag.
    always_comb begin
        last_d         = grant ? winner : last_q;
        hold_valid_d   = mem_req_o & ~mem_gnt_i;
        hold_src_d     = winner;
        protocol_err_d = protocol_err_q | (mem_rvalid_i & fifo_empty);
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q         <= LastInit;
            hold_valid_q   <= 1'b0;
            hold_src_q     <= SrcInstr;
            protocol_err_q <= 1'b0;
        end else begin
            last_q         <= last_d;
            hold_valid_q   <= hold_valid_d;
            hold_src_q     <= hold_src_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err_o = protocol_err_q;

    ibex_arb_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .src_i   (winner),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter (MAX_OUTSTANDING=2, DATA_FIRST=1).
module tb_ibex_mem_arbiter;

    logic        clk, rst_n;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        protocol_err;

    int total = 0;
    int bad   = 0;

    ibex_mem_arbiter #(
        .MAX_OUTSTANDING (2),
        .DATA_FIRST      (1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_addr_i   (instr_addr),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .mem_req_o      (mem_req),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rdata_i    (mem_rdata),
        .mem_err_i      (mem_err),
        .protocol_err_o (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        instr_req = 0; instr_addr = '0;
        data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 2 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    typedef struct {
        logic        ireq, dreq, dwe, gnt;
        logic [3:0]  dbe;
        logic [31:0] iaddr, daddr, dwdata;
        logic        e_req, e_we, e_igt, e_dgt;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    function automatic vec_t mk(logic ireq, logic dreq, logic dwe, logic [3:0] dbe,
                                logic [31:0] iaddr, logic [31:0] daddr, logic [31:0] dwdata,
                                logic gnt, logic e_req, logic [31:0] e_addr, logic e_we,
                                logic [3:0] e_be, logic [31:0] e_wdata, logic e_igt,
                                logic e_dgt);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.dbe = dbe;
        v.iaddr = iaddr; v.daddr = daddr; v.dwdata = dwdata; v.gnt = gnt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_igt = e_igt; v.e_dgt = e_dgt;
        return v;
    endfunction

    // Reference model state for the random phase.
    int          q[$];      // outstanding sources in grant order (0 instr, 1 data)
    int          last_w;    // side granted most recently
    bit          pend_v;    // a request was presented but not granted last cycle
    int          pend_w;
    bit          perr;
    bit          i_pend, d_pend, d_we_r;
    logic [3:0]  d_be_r;
    logic [31:0] i_addr_r, d_addr_r, d_wdata_r;

    initial begin
        vec_t vecs[7];
        rst_n = 0;
        idle();

        // Single-cycle arbitration checks, each from a fresh reset.
        vecs[0] = mk(0, 0, 0, 4'h0, 32'h80, 32'h1000_0000, 32'h0, 0,
                     0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        vecs[1] = mk(1, 0, 1, 4'h3, 32'h80, 32'h1000_0000, 32'hDEAD_BEEF, 0,
                     1, 32'h80, 0, 4'hF, 32'h0, 0, 0);
        vecs[2] = mk(1, 0, 1, 4'h3, 32'h84, 32'h1000_0000, 32'hDEAD_BEEF, 1,
                     1, 32'h84, 0, 4'hF, 32'h0, 1, 0);
        vecs[3] = mk(0, 1, 1, 4'h3, 32'h80, 32'h1000_0000, 32'hCAFE_0001, 1,
                     1, 32'h1000_0000, 1, 4'h3, 32'hCAFE_0001, 0, 1);
        vecs[4] = mk(1, 1, 0, 4'hC, 32'h80, 32'h2000_0004, 32'h1234_5678, 0,
                     1, 32'h2000_0004, 0, 4'hC, 32'h1234_5678, 0, 0);
        vecs[5] = mk(1, 1, 1, 4'h1, 32'h80, 32'h2000_0008, 32'h0000_00AA, 1,
                     1, 32'h2000_0008, 1, 4'h1, 32'h0000_00AA, 0, 1);
        vecs[6] = mk(0, 0, 1, 4'h1, 32'h80, 32'h2000_0008, 32'h0, 1,
                     0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            do_reset();
            instr_req = vecs[i].ireq; instr_addr = vecs[i].iaddr;
            data_req = vecs[i].dreq; data_we = vecs[i].dwe; data_be = vecs[i].dbe;
            data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata; mem_gnt = vecs[i].gnt;
            settle();
            chk($sformatf("vec%0d_req", i), mem_req, vecs[i].e_req);
            chk($sformatf("vec%0d_igt", i), instr_gnt, vecs[i].e_igt);
            chk($sformatf("vec%0d_dgt", i), data_gnt, vecs[i].e_dgt);
            if (vecs[i].e_req) begin
                chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
                chk($sformatf("vec%0d_be", i), mem_be, vecs[i].e_be);
                chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
        end

        // Reset state.
        do_reset();
        settle();
        chk("rst_perr", protocol_err, 0);
        chk("rst_req", mem_req, 0);

        // Fetch with same-cycle grant and next-cycle response.
        instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
        settle();
        chk("fetch_gnt", instr_gnt, 1);
        chk("fetch_addr", mem_addr, 32'h80);
        cyc();
        idle(); mem_rvalid = 1; mem_rdata = 32'h13;
        settle();
        chk("fetch_rvalid", instr_rvalid, 1);
        chk("fetch_rdata", instr_rdata, 32'h13);
        chk("fetch_d_rvalid", data_rvalid, 0);
        cyc();
        idle();

        // Both requesting every cycle: D, I, D, I with responses flowing back.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            instr_req = 1; instr_addr = 32'h100 + 32'(k * 4);
            data_req = 1; data_we = 0; data_be = 4'h3; data_addr = 32'h3000_0000;
            mem_gnt = 1; mem_rvalid = (k > 0); mem_rdata = 32'h50 + 32'(k);
            settle();
            chk($sformatf("rr%0d_dgt", k), data_gnt, (k % 2 == 0));
            chk($sformatf("rr%0d_igt", k), instr_gnt, (k % 2 == 1));
            if (k % 2 == 1) begin
                chk($sformatf("rr%0d_be", k), mem_be, 4'hF);
                chk($sformatf("rr%0d_addr", k), mem_addr, 32'h100 + 32'(k * 4));
            end
            if (k > 0) begin
                chk($sformatf("rr%0d_drv", k), data_rvalid, (k % 2 == 1));
                chk($sformatf("rr%0d_irv", k), instr_rvalid, (k % 2 == 0));
            end
            cyc();
        end
        idle();

        // Held choice: data write stays on the bus while its grant is withheld,
        // even though round-robin would now favour the instruction side.
        do_reset();
        data_req = 1; data_addr = 32'h2000_0000; data_be = 4'hF; mem_gnt = 1;
        settle();
        chk("hold_pre_dgt", data_gnt, 1);
        cyc();
        data_we = 1; data_be = 4'h3; data_addr = 32'h1000_0000; data_wdata = 32'h55;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        settle();
        chk("hold_pre_rv", data_rvalid, 1);
        chk("hold_c0_addr", mem_addr, 32'h1000_0000);
        cyc();
        mem_rvalid = 0;
        for (int k = 1; k <= 3; k++) begin
            instr_req = 1; instr_addr = 32'h80;
            mem_gnt = (k == 3);
            settle();
            chk($sformatf("hold_c%0d_addr", k), mem_addr, 32'h1000_0000);
            chk($sformatf("hold_c%0d_we", k), mem_we, 1);
            chk($sformatf("hold_c%0d_be", k), mem_be, 4'h3);
            chk($sformatf("hold_c%0d_igt", k), instr_gnt, 0);
            chk($sformatf("hold_c%0d_dgt", k), data_gnt, (k == 3));
            cyc();
        end
        data_req = 0; mem_gnt = 1;
        settle();
        chk("hold_after_igt", instr_gnt, 1);
        chk("hold_after_addr", mem_addr, 32'h80);
        cyc();
        idle();

        // Full at two outstanding; one response frees a slot next cycle.
        do_reset();
        instr_req = 1; instr_addr = 32'h200; mem_gnt = 1;
        settle();
        chk("full_g0", instr_gnt, 1);
        cyc();
        instr_req = 0; data_req = 1; data_addr = 32'h4000_0000; data_be = 4'hF;
        settle();
        chk("full_g1", data_gnt, 1);
        cyc();
        data_req = 0; instr_req = 1; instr_addr = 32'h204;
        settle();
        chk("full_req", mem_req, 0);
        chk("full_igt", instr_gnt, 0);
        cyc();
        mem_rvalid = 1; mem_rdata = 32'hA;
        settle();
        chk("full_same_req", mem_req, 0);
        chk("full_rv0_i", instr_rvalid, 1);
        chk("full_rv0_d", data_rvalid, 0);
        cyc();
        mem_rdata = 32'hB;
        settle();
        chk("full_back_req", mem_req, 1);
        chk("full_back_igt", instr_gnt, 1);
        chk("full_rv1_d", data_rvalid, 1);
        chk("full_rv1_rdata", data_rdata, 32'hB);
        cyc();
        instr_req = 0; mem_gnt = 0; mem_rdata = 32'hC; mem_err = 1;
        settle();
        chk("full_rv2_i", instr_rvalid, 1);
        chk("full_rv2_err", instr_err, 1);
        chk("full_rv2_derr", data_err, 0);
        cyc();
        idle();
        settle();
        chk("full_perr", protocol_err, 0);

        // Stray response with nothing outstanding.
        cyc();
        mem_rvalid = 1;
        settle();
        chk("stray_irv", instr_rvalid, 0);
        chk("stray_drv", data_rvalid, 0);
        cyc();
        mem_rvalid = 0;
        settle();
        chk("stray_perr", protocol_err, 1);

        // Outputs quiet during reset regardless of inputs; flag clears.
        instr_req = 1; data_req = 1; mem_gnt = 1; mem_rvalid = 1;
        rst_n = 0;
        #1;
        chk("inrst_req", mem_req, 0);
        chk("inrst_igt", instr_gnt, 0);
        chk("inrst_dgt", data_gnt, 0);
        chk("inrst_rv", instr_rvalid | data_rvalid, 0);
        chk("inrst_perr", protocol_err, 0);
        cyc();
        idle();
        cyc();
        rst_n = 1;
        settle();
        chk("rel_perr", protocol_err, 0);

        // Reset with two outstanding discards them.
        cyc();
        instr_req = 1; mem_gnt = 1;
        cyc();
        instr_req = 0; data_req = 1;
        cyc();
        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
        mem_rvalid = 1;
        settle();
        chk("mid_rst_rv", instr_rvalid | data_rvalid, 0);
        cyc();
        mem_rvalid = 0; instr_req = 1; data_req = 1; mem_gnt = 1;
        settle();
        chk("mid_rst_perr", protocol_err, 1);
        chk("mid_rst_dgt", data_gnt, 1);
        chk("mid_rst_igt", instr_gnt, 0);
        cyc();
        idle();

        // Random protocol-compliant traffic against the reference model.
        do_reset();
        q.delete();
        last_w = 0; pend_v = 0; pend_w = 0; perr = 0;
        i_pend = 0; d_pend = 0;
        for (int n = 0; n < 500; n++) begin
            int  w;
            bit  e_req, grant, popped;
            int  head;
            if (!i_pend && ($urandom % 3 == 0)) begin
                i_pend = 1; i_addr_r = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && ($urandom % 3 == 0)) begin
                d_pend = 1; d_we_r = 1'($urandom); d_be_r = 4'($urandom);
                d_addr_r = $urandom; d_wdata_r = $urandom;
            end
            instr_req = i_pend; instr_addr = i_addr_r;
            data_req = d_pend; data_we = d_we_r; data_be = d_be_r;
            data_addr = d_addr_r; data_wdata = d_wdata_r;
            mem_gnt = ($urandom % 4 != 0);
            mem_rvalid = (q.size() > 0) ? 1'($urandom) : ($urandom % 40 == 0);
            mem_rdata = $urandom; mem_err = 1'($urandom);

            if (pend_v) w = pend_w;
            else if (i_pend && !d_pend) w = 0;
            else if (d_pend && !i_pend) w = 1;
            else w = 1 - last_w;
            e_req  = (i_pend || d_pend) && (q.size() < 2);
            grant  = e_req && mem_gnt;
            popped = mem_rvalid && (q.size() > 0);
            head   = (q.size() > 0) ? q[0] : -1;

            settle();
            chk("rnd_req", mem_req, e_req);
            chk("rnd_igt", instr_gnt, grant && w == 0);
            chk("rnd_dgt", data_gnt, grant && w == 1);
            if (e_req) begin
                chk("rnd_addr", mem_addr, (w == 1) ? d_addr_r : i_addr_r);
                chk("rnd_we", mem_we, (w == 1) ? d_we_r : 1'b0);
                chk("rnd_be", mem_be, (w == 1) ? d_be_r : 4'hF);
                chk("rnd_wdata", mem_wdata, (w == 1) ? d_wdata_r : 32'h0);
            end
            chk("rnd_irv", instr_rvalid, popped && head == 0);
            chk("rnd_drv", data_rvalid, popped && head == 1);
            if (popped) begin
                chk("rnd_rdata", (head == 0) ? instr_rdata : data_rdata, mem_rdata);
                chk("rnd_err", (head == 0) ? instr_err : data_err, mem_err);
            end
            chk("rnd_perr", protocol_err, perr);

            if (mem_rvalid && q.size() == 0) perr = 1;
            if (popped) void'(q.pop_front());
            if (grant) begin
                q.push_back(w);
                last_w = w;
                if (w == 0) i_pend = 0; else d_pend = 0;
            end
            pend_v = e_req && !mem_gnt;
            pend_w = w;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
